// File: rtl/data_row_loader_pkg.sv
// Shared widths, address limit and FSM encoding for the data RAM row loader.
package data_row_loader_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROW_W  = 3 * WORD_W;
  localparam logic [ADDR_W-1:0] LAST_ADDRESS = 16'd128;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_X = 3'd1,
    S_WAIT_Y = 3'd2,
    S_WAIT_Z = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // One extra bit keeps base+count-1 from wrapping back into the legal range.
  function automatic logic range_exceeded(input logic [ADDR_W-1:0] base,
                                          input logic [ADDR_W-1:0] count);
    logic [ADDR_W:0] last_row;
    last_row = {1'b0, base} + {1'b0, count} - {{ADDR_W{1'b0}}, 1'b1};
    return (last_row > {1'b0, LAST_ADDRESS});
  endfunction

endpackage

// File: rtl/data_row_loader_if.sv
// Command, word-stream and RAM write-port signals of the row loader.
interface data_row_loader_if;
  import data_row_loader_pkg::*;

  logic              iStart;
  logic [ADDR_W-1:0] iBaseAddress;
  logic [ADDR_W-1:0] iRowCount;
  logic              iWordValid;
  logic [WORD_W-1:0] iWord;
  logic              oWordReady;
  logic              oWriteEnable;
  logic [ADDR_W-1:0] oWriteAddress;
  logic [ROW_W-1:0]  oDataOut;
  logic              oBusy;
  logic              oDone;
  logic              oError;

  modport slave (
    input  iStart, iBaseAddress, iRowCount, iWordValid, iWord,
    output oWordReady, oWriteEnable, oWriteAddress, oDataOut, oBusy, oDone, oError
  );

  modport master (
    output iStart, iBaseAddress, iRowCount, iWordValid, iWord,
    input  oWordReady, oWriteEnable, oWriteAddress, oDataOut, oBusy, oDone, oError
  );

endinterface

// File: rtl/data_row_loader.sv
// Packs x/y/z words into 96-bit rows and writes them to consecutive data RAM
// addresses starting at a commanded base.
module data_row_loader
  import data_row_loader_pkg::*;
(
  input logic               Clock,
  input logic               Reset,
  data_row_loader_if.slave  bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_take;
  logic              w_range_bad;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [WORD_W-1:0] r_x;
  logic [WORD_W-1:0] r_y;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ROW_W-1:0]  r_data;
  logic              r_error;

  assign w_take      = bus.iWordValid && bus.oWordReady;
  assign w_range_bad = range_exceeded(bus.iBaseAddress, bus.iRowCount);

  assign bus.oWordReady    = (r_state == S_WAIT_X) || (r_state == S_WAIT_Y) ||
                             (r_state == S_WAIT_Z);
  assign bus.oWriteEnable  = (r_state == S_WRITE);
  assign bus.oBusy         = (r_state != S_IDLE);
  assign bus.oDone         = (r_state == S_DONE);
  assign bus.oError        = r_error;
  assign bus.oWriteAddress = r_wr_addr;
  assign bus.oDataOut      = r_data;

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.iStart) begin
          w_next_state = S_IDLE;
        end else if (bus.iRowCount == 16'd0) begin
          w_next_state = S_DONE;
        end else if (w_range_bad) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT_X;
        end
      end
      S_WAIT_X: w_next_state = w_take ? S_WAIT_Y : S_WAIT_X;
      S_WAIT_Y: w_next_state = w_take ? S_WAIT_Z : S_WAIT_Y;
      S_WAIT_Z: w_next_state = w_take ? S_WRITE  : S_WAIT_Z;
      S_WRITE: begin
        if (r_remaining == 16'd1) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WAIT_X;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command latch, row packer and write-port registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_addr      <= 16'd0;
      r_remaining <= 16'd0;
      r_x         <= 32'd0;
      r_y         <= 32'd0;
      r_wr_addr   <= 16'd0;
      r_data      <= 96'd0;
      r_error     <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.iStart) begin
            r_addr      <= bus.iBaseAddress;
            r_remaining <= bus.iRowCount;
            r_error     <= (bus.iRowCount != 16'd0) && w_range_bad;
          end
        end
        S_WAIT_X: if (w_take) r_x <= bus.iWord;
        S_WAIT_Y: if (w_take) r_y <= bus.iWord;
        S_WAIT_Z: begin
          // Row and address are frozen here so they hold after the strobe.
          if (w_take) begin
            r_wr_addr <= r_addr;
            r_data    <= {r_x, r_y, bus.iWord};
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + 16'd1;
          r_remaining <= r_remaining - 16'd1;
        end
        default: r_error <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_row_loader.sv
// Directed bench for data_row_loader with a transaction-level reference model.
module tb_data_row_loader;

  logic Clock;
  logic Reset;
  data_row_loader_if bus();

  data_row_loader dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: transfer-level view of the loader
  bit          m_seen   = 1'b0;
  bit          m_active = 1'b0;
  bit          m_write  = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;
  bit          m_take;
  int          m_addr   = 0;
  int          m_left   = 0;
  logic [31:0] m_row[$];
  logic [15:0] m_wa     = 16'd0;
  logic [95:0] m_wd     = 96'd0;

  // Observation logs
  logic [15:0] log_addr[$];
  logic [95:0] log_data[$];
  int          log_cyc[$];
  int          cycle         = 0;
  int          done_cnt      = 0;
  int          err_cnt       = 0;
  int          busy_cnt      = 0;
  int          words_taken   = 0;
  int          last_done_cyc = 0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_seen   = 1'b1;
      m_active = 1'b0;
      m_write  = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_row.delete();
      m_wa     = 16'd0;
      m_wd     = 96'd0;
    end else begin
      m_take = m_active && !m_write && !m_done && (bus.iWordValid === 1'b1);
      if (m_take) words_taken++;
      m_err = 1'b0;
      if (m_done) begin
        m_done   = 1'b0;
        m_active = 1'b0;
      end else if (m_write) begin
        m_write = 1'b0;
        m_addr++;
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (!m_active && bus.iStart) begin
        if (bus.iRowCount == 16'd0) begin
          m_active = 1'b1;
          m_done   = 1'b1;
        end else if (int'(bus.iBaseAddress) + int'(bus.iRowCount) - 1 > 128) begin
          m_err = 1'b1;
        end else begin
          m_active = 1'b1;
          m_addr   = int'(bus.iBaseAddress);
          m_left   = int'(bus.iRowCount);
          m_row.delete();
        end
      end
      if (m_take) begin
        m_row.push_back(bus.iWord);
        if (m_row.size() == 3) begin
          m_wd    = {m_row[0], m_row[1], m_row[2]};
          m_wa    = 16'(m_addr);
          m_write = 1'b1;
          m_row.delete();
        end
      end
    end
    #1;
    if (m_seen) begin
      cycle++;
      chk("ready", bus.oWordReady,   m_active && !m_write && !m_done);
      chk("wen",   bus.oWriteEnable, m_write);
      chk("busy",  bus.oBusy,        m_active);
      chk("done",  bus.oDone,        m_done);
      chk("error", bus.oError,       m_err);
      chk("waddr", bus.oWriteAddress, m_wa);
      chk("wdata", bus.oDataOut,     m_wd);
      if (bus.oWriteEnable === 1'b1) begin
        log_addr.push_back(bus.oWriteAddress);
        log_data.push_back(bus.oDataOut);
        log_cyc.push_back(cycle);
      end
      if (bus.oDone === 1'b1) begin
        done_cnt++;
        last_done_cyc = cycle;
      end
      if (bus.oError === 1'b1) err_cnt++;
      if (bus.oBusy === 1'b1) busy_cnt++;
    end
  end

  task automatic start(input logic [15:0] base, input logic [15:0] count);
    @(negedge Clock);
    bus.iStart       = 1'b1;
    bus.iBaseAddress = base;
    bus.iRowCount    = count;
    @(negedge Clock);
    bus.iStart       = 1'b0;
  endtask

  // Offer n words first, first+1, ...; toggle offers them only every other cycle.
  task automatic feed(input int n, input int first, input bit toggle);
    int idx   = 0;
    int cyc   = 0;
    int phase = 0;
    bit v;
    while (idx < n && cyc < 200) begin
      @(negedge Clock);
      cyc++;
      v = toggle ? ((phase % 2) == 0) : 1'b1;
      phase++;
      bus.iWordValid = v;
      bus.iWord      = 32'(first + idx);
      if (v && bus.oWordReady) idx++;
    end
    chk("feed_timeout", 128'(idx), 128'(n));
    @(negedge Clock);
    bus.iWordValid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
    end while (bus.oBusy && cyc < budget);
    chk("idle_timeout", bus.oBusy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  int w0, d0, e0, t0, b0, n;

  initial begin
    Reset            = 1'b1;
    bus.iStart       = 1'b0;
    bus.iBaseAddress = 16'd0;
    bus.iRowCount    = 16'd0;
    bus.iWordValid   = 1'b0;
    bus.iWord        = 32'd0;
    repeat (3) @(negedge Clock);
    chk("rst_busy",  bus.oBusy,         1'b0);
    chk("rst_ready", bus.oWordReady,    1'b0);
    chk("rst_wen",   bus.oWriteEnable,  1'b0);
    chk("rst_waddr", bus.oWriteAddress, 16'd0);
    chk("rst_wdata", bus.oDataOut,      96'd0);
    Reset = 1'b0;

    // Base 0, count 2, continuous words 1..6
    w0 = log_addr.size();
    start(16'd0, 16'd2);
    feed(6, 1, 1'b0);
    wait_idle(50);
    chk("t1_nwr", 128'(log_addr.size() - w0), 128'd2);
    if (log_addr.size() - w0 == 2) begin
      chk("t1_a0",  log_addr[w0],     16'd0);
      chk("t1_d0",  log_data[w0],     {32'd1, 32'd2, 32'd3});
      chk("t1_a1",  log_addr[w0+1],   16'd1);
      chk("t1_d1",  log_data[w0+1],   {32'd4, 32'd5, 32'd6});
      chk("t1_gap", 128'(log_cyc[w0+1] - log_cyc[w0]), 128'd4);
      chk("t1_done_lat", 128'(last_done_cyc - log_cyc[w0+1]), 128'd1);
    end

    // Same transfer with words offered every other cycle
    w0 = log_addr.size();
    start(16'd0, 16'd2);
    feed(6, 1, 1'b1);
    wait_idle(80);
    chk("t2_nwr", 128'(log_addr.size() - w0), 128'd2);
    if (log_addr.size() - w0 == 2) begin
      chk("t2_a0", log_addr[w0],   16'd0);
      chk("t2_d0", log_data[w0],   {32'd1, 32'd2, 32'd3});
      chk("t2_a1", log_addr[w0+1], 16'd1);
      chk("t2_d1", log_data[w0+1], {32'd4, 32'd5, 32'd6});
    end

    // Range error: 127 + 3 - 1 = 129 > 128, words offered but not consumed
    w0 = log_addr.size(); e0 = err_cnt; t0 = words_taken; b0 = busy_cnt;
    bus.iWordValid = 1'b1;
    bus.iWord      = 32'hdead_beef;
    start(16'd127, 16'd3);
    repeat (3) @(negedge Clock);
    bus.iWordValid = 1'b0;
    chk("t3_err",   128'(err_cnt - e0),          128'd1);
    chk("t3_nwr",   128'(log_addr.size() - w0),  128'd0);
    chk("t3_taken", 128'(words_taken - t0),      128'd0);
    chk("t3_busy",  128'(busy_cnt - b0),         128'd0);

    // Top-of-range transfer: rows 126..128
    w0 = log_addr.size();
    start(16'd126, 16'd3);
    feed(9, 100, 1'b0);
    wait_idle(50);
    chk("t4_nwr", 128'(log_addr.size() - w0), 128'd3);
    if (log_addr.size() - w0 == 3) begin
      chk("t4_a0", log_addr[w0],   16'd126);
      chk("t4_a2", log_addr[w0+2], 16'd128);
      chk("t4_d2", log_data[w0+2], {32'd106, 32'd107, 32'd108});
    end

    // Count 0: one busy cycle, a done pulse, nothing consumed
    w0 = log_addr.size(); d0 = done_cnt; t0 = words_taken; b0 = busy_cnt;
    bus.iWordValid = 1'b1;
    bus.iWord      = 32'h1234_5678;
    start(16'd5, 16'd0);
    repeat (3) @(negedge Clock);
    bus.iWordValid = 1'b0;
    chk("t5_done",  128'(done_cnt - d0),        128'd1);
    chk("t5_nwr",   128'(log_addr.size() - w0), 128'd0);
    chk("t5_taken", 128'(words_taken - t0),     128'd0);
    chk("t5_busy",  128'(busy_cnt - b0),        128'd1);

    // New start during WAIT_Y is ignored
    w0 = log_addr.size();
    start(16'd10, 16'd1);
    bus.iWordValid = 1'b1;
    bus.iWord      = 32'd7;
    @(negedge Clock);
    bus.iWordValid   = 1'b0;
    bus.iStart       = 1'b1;
    bus.iBaseAddress = 16'd50;
    bus.iRowCount    = 16'd5;
    @(negedge Clock);
    bus.iStart = 1'b0;
    feed(2, 8, 1'b0);
    wait_idle(50);
    chk("t6_nwr", 128'(log_addr.size() - w0), 128'd1);
    if (log_addr.size() - w0 == 1) begin
      chk("t6_a0", log_addr[w0], 16'd10);
      chk("t6_d0", log_data[w0], {32'd7, 32'd8, 32'd9});
    end

    // Reset after Y accepted discards the partial row
    w0 = log_addr.size(); d0 = done_cnt;
    start(16'd20, 16'd2);
    feed(2, 40, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("t7_busy",  bus.oBusy,         1'b0);
    chk("t7_waddr", bus.oWriteAddress, 16'd0);
    chk("t7_wdata", bus.oDataOut,      96'd0);
    repeat (2) @(negedge Clock);
    chk("t7_nwr",  128'(log_addr.size() - w0), 128'd0);
    chk("t7_done", 128'(done_cnt - d0),        128'd0);
    start(16'd30, 16'd1);
    feed(3, 60, 1'b0);
    wait_idle(50);
    n = log_addr.size();
    chk("t7_nwr2", 128'(n - w0), 128'd1);
    if (n - w0 == 1) begin
      chk("t7_a0", log_addr[w0], 16'd30);
      chk("t7_d0", log_data[w0], {32'd60, 32'd61, 32'd62});
    end

    repeat (2) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
